// File: rtl/watch_pkg.sv
// Shared definitions for the watch counters.
//   sw_state_t    : stopwatch state encoding
//   *_MAX_TENS/ONES : BCD wrap limits (59 and 99) used by the BCD digit counters
//   sw_is_running / sw_is_split : output decode for a given stopwatch state
package watch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'b00,
    SW_RUN   = 2'b01,
    SW_SPLIT = 2'b10,
    SW_STOP  = 2'b11
  } sw_state_t;

  localparam logic [3:0] MAX59_TENS = 4'd5;
  localparam logic [3:0] MAX59_ONES = 4'd9;
  localparam logic [3:0] MAX99_TENS = 4'd9;
  localparam logic [3:0] MAX99_ONES = 4'd9;

  function automatic logic sw_is_running(input sw_state_t st);
    return (st == SW_RUN) || (st == SW_SPLIT);
  endfunction

  function automatic logic sw_is_split(input sw_state_t st);
    return (st == SW_IDLE) || (st == SW_SPLIT);
  endfunction

endpackage

// File: rtl/stopwatch_unit_bcd_mod_counter.sv
// Two-digit BCD modulo counter, wraps MAX -> 00.
// Ports:
//   clk, rst   clock, async active-low reset
//   clr        synchronous clear to 00 (priority over inc)
//   inc        advance by one
//   bcd[7:0]   {tens, ones}
//   carry      high in the cycle inc is applied at MAX (wrap to 00)
module bcd_mod_counter #(
  parameter logic [3:0] MAX_TENS = 4'd5,
  parameter logic [3:0] MAX_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] bcd,
  output logic       carry
);

  logic [3:0] tens;
  logic [3:0] ones;
  logic       at_max;

  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign carry  = inc && at_max;
  assign bcd    = {tens, ones};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_unit.sv
// Stopwatch control and datapath: BCD MM:SS.CC live counter with start/stop,
// split (frozen display) and clear.
// Ports:
//   clk, rst           clock, async active-low reset
//   stopwatch_mode_en  buttons are honoured only while high; counting is unaffected
//   mode, set          single-cycle button pulses; set has priority when both arrive
//   sw_min/sec/cs      displayed BCD time (frozen while in SPLIT)
//   running            live counter is advancing (RUN, SPLIT)
//   split_mode         high in IDLE and SPLIT, lets the mode FSM leave on a mode press
//   overflow           sticky, set when the live count wraps 59:59.99 -> 00:00.00
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting, display tracks live count
// SPLIT | counting, display frozen at the value latched on entry
// STOP  | paused, count and prescaler hold
module stopwatch_unit
  import watch_pkg::*;
#(
  parameter int CS_DIV = 100000,
  parameter int PS_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stopwatch_mode_en,
  input  logic       mode,
  input  logic       set,
  output logic [7:0] sw_min,
  output logic [7:0] sw_sec,
  output logic [7:0] sw_cs,
  output logic       running,
  output logic       split_mode,
  output logic       overflow
);

  sw_state_t       state;
  sw_state_t       state_nxt;
  logic            set_ev;
  logic            mode_ev;
  logic            clr;
  logic            latch_en;
  logic [PS_W-1:0] ps_q;
  logic            tick;
  logic            cs_inc;
  logic            sec_inc;
  logic            min_inc;
  logic            cs_carry;
  logic            sec_carry;
  logic            min_carry;
  logic [7:0]      cs_bcd;
  logic [7:0]      sec_bcd;
  logic [7:0]      min_bcd;
  logic [23:0]     split_q;

  assign set_ev  = set && stopwatch_mode_en;
  assign mode_ev = mode && stopwatch_mode_en && !set_ev;

  always_comb begin
    state_nxt = state;
    unique case (state)
      SW_IDLE:  if (set_ev) state_nxt = SW_RUN;
      SW_RUN: begin
        if (set_ev)       state_nxt = SW_STOP;
        else if (mode_ev) state_nxt = SW_SPLIT;
      end
      SW_SPLIT: if (set_ev) state_nxt = SW_RUN;
      SW_STOP: begin
        if (set_ev)       state_nxt = SW_RUN;
        else if (mode_ev) state_nxt = SW_IDLE;
      end
      default:  state_nxt = SW_IDLE;
    endcase
  end

  // running/split_mode are registered alongside the state so the mode press
  // that enters SPLIT cannot also be seen as an exit request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SW_IDLE;
      running    <= 1'b0;
      split_mode <= 1'b1;
    end else begin
      state      <= state_nxt;
      running    <= sw_is_running(state_nxt);
      split_mode <= sw_is_split(state_nxt);
    end
  end

  assign clr      = (state == SW_STOP) && mode_ev;
  assign latch_en = (state == SW_RUN) && mode_ev;

  // Prescaler advances on registered running, so the edge that enters RUN
  // does not count and the first tick lands CS_DIV cycles later.
  assign tick = running && (ps_q == PS_W'(CS_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else if (clr) begin
      ps_q <= '0;
    end else if (running) begin
      ps_q <= tick ? '0 : ps_q + 1'b1;
    end
  end

  assign cs_inc  = tick;
  assign sec_inc = cs_carry;
  assign min_inc = sec_carry;

  bcd_mod_counter #(.MAX_TENS(MAX99_TENS), .MAX_ONES(MAX99_ONES)) u_cs (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (cs_inc),
    .bcd   (cs_bcd),
    .carry (cs_carry)
  );

  bcd_mod_counter #(.MAX_TENS(MAX59_TENS), .MAX_ONES(MAX59_ONES)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (sec_inc),
    .bcd   (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX_TENS(MAX59_TENS), .MAX_ONES(MAX59_ONES)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (min_inc),
    .bcd   (min_bcd),
    .carry (min_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (min_carry) begin
      overflow <= 1'b1;
    end
  end

  // Split captures the value being displayed at the moment of the press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      split_q <= '0;
    end else if (latch_en) begin
      split_q <= {min_bcd, sec_bcd, cs_bcd};
    end
  end

  assign sw_min = (state == SW_SPLIT) ? split_q[23:16] : min_bcd;
  assign sw_sec = (state == SW_SPLIT) ? split_q[15:8]  : sec_bcd;
  assign sw_cs  = (state == SW_SPLIT) ? split_q[7:0]   : cs_bcd;

endmodule

// File: tb/tb_stopwatch_unit.sv
module tb_stopwatch_unit;

  localparam int CS_DIV = 4;
  localparam int PS_W   = 3;
  localparam int FULL   = 360000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_SPLIT = 2;
  localparam int M_STOP  = 3;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic       mode = 1'b0;
  logic       set  = 1'b0;
  logic [7:0] sw_min;
  logic [7:0] sw_sec;
  logic [7:0] sw_cs;
  logic       running;
  logic       split_mode;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  // reference model: whole-centisecond counts, not digits
  int m_st;
  int live;
  int frozen;
  int ps;
  bit ovf;

  stopwatch_unit #(.CS_DIV(CS_DIV), .PS_W(PS_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .stopwatch_mode_en (en),
    .mode              (mode),
    .set               (set),
    .sw_min            (sw_min),
    .sw_sec            (sw_sec),
    .sw_cs             (sw_cs),
    .running           (running),
    .split_mode        (split_mode),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; live = 0; frozen = 0; ps = 0; ovf = 0;
  endtask

  task automatic model_edge(input bit s, input bit m, input bit e);
    bit se, me, run_old;
    int live_old;
    se = s && e;
    me = m && e && !se;
    run_old = (m_st == M_RUN) || (m_st == M_SPLIT);
    live_old = live;
    if (run_old) begin
      if (ps == CS_DIV - 1) begin
        ps = 0;
        if (live == FULL - 1) begin live = 0; ovf = 1; end
        else live = live + 1;
      end else begin
        ps = ps + 1;
      end
    end
    case (m_st)
      M_IDLE:  if (se) m_st = M_RUN;
      M_RUN: begin
        if (se) m_st = M_STOP;
        else if (me) begin m_st = M_SPLIT; frozen = live_old; end
      end
      M_SPLIT: if (se) m_st = M_RUN;
      default: begin
        if (se) m_st = M_RUN;
        else if (me) begin m_st = M_IDLE; live = 0; ps = 0; ovf = 0; end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    int d;
    d = (m_st == M_SPLIT) ? frozen : live;
    check({tag, " min"}, 32'(sw_min), 32'(bcd2(d / 6000)));
    check({tag, " sec"}, 32'(sw_sec), 32'(bcd2((d / 100) % 60)));
    check({tag, " cs"},  32'(sw_cs),  32'(bcd2(d % 100)));
    check({tag, " running"}, 32'(running), 32'((m_st == M_RUN) || (m_st == M_SPLIT)));
    check({tag, " split_mode"}, 32'(split_mode), 32'((m_st == M_IDLE) || (m_st == M_SPLIT)));
    check({tag, " overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // called at a negedge; applies one cycle of inputs and checks after the edge
  task automatic step(input bit s, input bit m, input bit e, input string tag);
    set = s; mode = m; en = e;
    @(posedge clk);
    model_edge(s, m, e);
    @(negedge clk);
    set = 1'b0; mode = 1'b0; en = 1'b1;
    check_all(tag);
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    check_all("reset");
    check("reset split_mode", 32'(split_mode), 32'd1);
    rst = 1'b1;
    en  = 1'b1;

    // start, first ticks
    step(1'b1, 1'b0, 1'b1, "t1 start");
    check("t1 running", 32'(running), 32'd1);
    check("t1 split_mode", 32'(split_mode), 32'd0);
    run_cycles(3, "t1 pre");
    check("t1 cs0", 32'(sw_cs), 32'h00);
    run_cycles(1, "t1 tick1");
    check("t1 cs1", 32'(sw_cs), 32'h01);
    run_cycles(4, "t1 tick2");
    check("t1 cs2", 32'(sw_cs), 32'h02);

    // cs -> sec carry
    run_cycles(97 * CS_DIV, "t2 run");
    check("t2 cs99", 32'(sw_cs), 32'h99);
    run_cycles(CS_DIV, "t2 carry");
    check("t2 cs wrap", 32'(sw_cs), 32'h00);
    check("t2 sec1", 32'(sw_sec), 32'h01);

    // stop / hold / resume / clear
    run_cycles(2, "t4 pre");
    step(1'b1, 1'b0, 1'b1, "t4 stop");
    run_cycles(10, "t4 hold");
    check("t4 hold cs", 32'(sw_cs), 32'h00);
    check("t4 hold sec", 32'(sw_sec), 32'h01);
    step(1'b1, 1'b0, 1'b1, "t4 resume");
    run_cycles(1, "t4 resume tick");
    check("t4 resumed cs", 32'(sw_cs), 32'h01);
    step(1'b1, 1'b0, 1'b1, "t4 stop2");
    step(1'b0, 1'b1, 1'b1, "t4 clear");
    check("t4 clr cs", 32'(sw_cs), 32'h00);
    check("t4 clr sec", 32'(sw_sec), 32'h00);
    check("t4 clr split_mode", 32'(split_mode), 32'd1);
    check("t4 clr running", 32'(running), 32'd0);

    // preload 59:59.99 by forcing digit increments, then wrap
    force dut.cs_inc = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    release dut.cs_inc;
    live = 99;
    force dut.sec_inc = 1'b1;
    repeat (3599) @(posedge clk);
    @(negedge clk);
    release dut.sec_inc;
    live = FULL - 1;
    check_all("t2 preload");
    check("t2 preload min", 32'(sw_min), 32'h59);
    step(1'b1, 1'b0, 1'b1, "t2 start");
    run_cycles(CS_DIV - 1, "t2 pre wrap");
    check("t2 pre wrap cs", 32'(sw_cs), 32'h99);
    run_cycles(1, "t2 wrap");
    check("t2 wrap min", 32'(sw_min), 32'h00);
    check("t2 wrap cs", 32'(sw_cs), 32'h00);
    check("t2 overflow", 32'(overflow), 32'd1);

    // split at 00:01.23
    run_cycles(123 * CS_DIV, "t3 run");
    run_cycles(1, "t3 run");
    step(1'b0, 1'b1, 1'b1, "t3 split");
    check("t3 split_mode", 32'(split_mode), 32'd1);
    check("t3 frozen sec", 32'(sw_sec), 32'h01);
    check("t3 frozen cs", 32'(sw_cs), 32'h23);
    run_cycles(20, "t3 frozen");
    check("t3 still frozen cs", 32'(sw_cs), 32'h23);
    step(1'b0, 1'b1, 1'b1, "t3 mode in split");
    step(1'b1, 1'b0, 1'b1, "t3 release");
    check("t3 release split_mode", 32'(split_mode), 32'd0);

    // buttons ignored while not in stopwatch mode
    step(1'b1, 1'b0, 1'b0, "t5 set masked");
    step(1'b0, 1'b1, 1'b0, "t5 mode masked");
    check("t5 running", 32'(running), 32'd1);
    run_cycles(9, "t5 count");

    // set wins over mode; async reset mid-run
    step(1'b1, 1'b1, 1'b1, "t6 both");
    check("t6 stop running", 32'(running), 32'd0);
    check("t6 stop split_mode", 32'(split_mode), 32'd0);
    step(1'b1, 1'b0, 1'b1, "t6 resume");
    run_cycles(7, "t6 run");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6 rst cs", 32'(sw_cs), 32'h00);
    check("t6 rst sec", 32'(sw_sec), 32'h00);
    check("t6 rst running", 32'(running), 32'd0);
    check("t6 rst split_mode", 32'(split_mode), 32'd1);
    check("t6 rst overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    check_all("t6 in reset");
    rst = 1'b1;

    // random buttons against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 23) == 0, ($urandom % 17) == 0, ($urandom % 4) != 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
